// File: rtl/lrrr_pkg.sv
// lrrr_pkg: shared state type and widths for the Lrrr boss controller
package lrrr_pkg;
  typedef enum logic [1:0] {IDLE, ARRIVE, ACTIVE, DEFEATED} lrrr_state_t;
  localparam int FRAME_CNT_W = 8;
  localparam int HP_W = 4;
endpackage

// File: rtl/lrrr_controller_frame_countdown.sv
// frame_countdown: loadable frame down counter with a one-clk expiry strobe
module frame_countdown
  import lrrr_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   load,
  input  logic                   startOfFrame,
  input  logic [FRAME_CNT_W-1:0] loadValue,
  output logic                   expired
);
  logic [FRAME_CNT_W-1:0] count;
  // Expiry is decoded from the pre-decrement count so a reload can use it without a loop.
  assign expired = startOfFrame && count == FRAME_CNT_W'(1);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) count <= '0;
    else if (load) count <= loadValue;
    else if (startOfFrame && count != '0) count <= count - FRAME_CNT_W'(1);
endmodule

// File: rtl/lrrr_controller.sv
// lrrr_controller: Lrrr boss phase FSM with arrival delay, dive timer and hit handling
module lrrr_controller
  import lrrr_pkg::*;
#(
  parameter int WAIT_FRAMES   = 90,
  parameter int TOGGLE_PERIOD = 45,
  parameter int HIT_POINTS    = 5,
  parameter int HIT_COOLDOWN  = 15
)(
  input  logic            clk,
  input  logic            resetN,
  input  logic            startOfFrame,
  input  logic            gameStart,
  input  logic            hitIn,
  output logic            waiting,
  output logic            toggleY,
  output logic [HP_W-1:0] hitPoints,
  output logic            invulnerable,
  output logic            defeatedPulse
);
  localparam logic [FRAME_CNT_W-1:0] WAIT_LOAD = FRAME_CNT_W'(WAIT_FRAMES == 0 ? 1 : WAIT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] DIVE_LOAD = FRAME_CNT_W'(TOGGLE_PERIOD);
  localparam logic [FRAME_CNT_W-1:0] COOL_LOAD = FRAME_CNT_W'(HIT_COOLDOWN);
  localparam logic [HP_W-1:0]        HP_LOAD   = HP_W'(HIT_POINTS);
  lrrr_state_t state;
  logic hitD, arriveExp, diveExp, coolExp, enterActive, hitOk, killHit;
  assign enterActive = state == ARRIVE && arriveExp && !gameStart;
  // gameStart outranks a coincident hit, so the hit is dropped here.
  assign hitOk   = state == ACTIVE && !invulnerable && hitIn && !hitD && !gameStart;
  assign killHit = hitOk && hitPoints == HP_W'(1);
  frame_countdown arriveCnt (
    .clk(clk), .resetN(resetN), .load(gameStart), .startOfFrame(startOfFrame),
    .loadValue(WAIT_LOAD), .expired(arriveExp)
  );
  frame_countdown diveCnt (
    .clk(clk), .resetN(resetN), .load(enterActive || diveExp), .startOfFrame(startOfFrame),
    .loadValue(DIVE_LOAD), .expired(diveExp)
  );
  frame_countdown coolCnt (
    .clk(clk), .resetN(resetN), .load(hitOk), .startOfFrame(startOfFrame),
    .loadValue(COOL_LOAD), .expired(coolExp)
  );
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state         <= IDLE;
      waiting       <= 1'b1;
      toggleY       <= 1'b0;
      hitPoints     <= HP_LOAD;
      invulnerable  <= 1'b0;
      defeatedPulse <= 1'b0;
      hitD          <= 1'b0;
    end else begin
      hitD          <= hitIn;
      defeatedPulse <= 1'b0;
      if (gameStart) begin
        state        <= ARRIVE;
        waiting      <= 1'b1;
        toggleY      <= 1'b0;
        hitPoints    <= HP_LOAD;
        invulnerable <= 1'b0;
      end else if (enterActive) begin
        state   <= ACTIVE;
        waiting <= 1'b0;
      end else if (killHit) begin
        state         <= DEFEATED;
        waiting       <= 1'b1;
        toggleY       <= 1'b0;
        hitPoints     <= '0;
        invulnerable  <= 1'b0;
        defeatedPulse <= 1'b1;
      end else if (state == ACTIVE) begin
        toggleY      <= diveExp || (toggleY && !startOfFrame);
        invulnerable <= hitOk || (invulnerable && !coolExp);
        hitPoints    <= hitPoints - HP_W'(hitOk);
      end
    end
endmodule

// File: tb/tb_lrrr_controller.sv
// tb_lrrr_controller: directed self-checking bench for lrrr_controller
module tb_lrrr_controller;
  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, gameStart = 1'b0, hitIn = 1'b0;
  logic waiting, toggleY, invulnerable, defeatedPulse;
  logic [3:0] hitPoints;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  lrrr_controller #(
    .WAIT_FRAMES(3), .TOGGLE_PERIOD(2), .HIT_POINTS(5), .HIT_COOLDOWN(2)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameStart(gameStart),
    .hitIn(hitIn), .waiting(waiting), .toggleY(toggleY), .hitPoints(hitPoints),
    .invulnerable(invulnerable), .defeatedPulse(defeatedPulse)
  );

  // Inputs change at the falling edge; outputs are observed at the next falling edge.
  task automatic step(input logic s, input logic g, input logic h);
    startOfFrame = s;
    gameStart = g;
    hitIn = h;
    @(negedge clk);
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    step(1, 1, 1);
    checks++;
    if ({hitPoints, invulnerable, toggleY, waiting, defeatedPulse} !== 8'b0101_0010) begin
      fails++;
      $display("FAIL reset_values got=%b want=%b", {hitPoints, invulnerable, toggleY, waiting, defeatedPulse}, 8'b0101_0010);
    end
    resetN = 1'b1;
    step(0, 0, 0);
    step(1, 0, 0);
    checks++;
    if (waiting !== 1'b1) begin
      fails++;
      $display("FAIL idle_ignores_frames waiting=%b want=1", waiting);
    end
  endtask

  task automatic test_arrive;
    step(1, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (waiting !== (k < 3) || toggleY !== 1'b0) begin
          fails++;
          $display("FAIL arrive frame=%0d waiting=%b toggleY=%b want waiting=%b toggleY=0", k, waiting, toggleY, k < 3);
        end
        if (j < 2) step(0, 0, 0);
      end
    end
  endtask

  task automatic test_dive;
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 0);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (toggleY !== (k % 2 == 0)) begin
          fails++;
          $display("FAIL dive frame=%0d toggleY=%b want=%b", k, toggleY, k % 2 == 0);
        end
        step(0, 0, 0);
      end
    end
  endtask

  task automatic test_hit_hold;
    step(0, 0, 1);
    checks++;
    if (hitPoints !== 4'd4 || invulnerable !== 1'b1) begin
      fails++;
      $display("FAIL hold_first_hit hp=%0d inv=%b want hp=4 inv=1", hitPoints, invulnerable);
    end
    for (int i = 1; i < 100; i++) begin
      step(i % 10 == 0, 0, 1);
      if (i == 10 || i == 20) begin
        checks++;
        if (invulnerable !== (i == 10)) begin
          fails++;
          $display("FAIL cooldown clk=%0d inv=%b want=%b", i, invulnerable, i == 10);
        end
      end
    end
    checks++;
    if (hitPoints !== 4'd4) begin
      fails++;
      $display("FAIL hold_single_decrement hp=%0d want=4", hitPoints);
    end
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    checks++;
    if (hitPoints !== 4'd3 || invulnerable !== 1'b1) begin
      fails++;
      $display("FAIL hit_in_cooldown hp=%0d inv=%b want hp=3 inv=1", hitPoints, invulnerable);
    end
    step(1, 0, 0);
    step(1, 0, 0);
    checks++;
    if (invulnerable !== 1'b0) begin
      fails++;
      $display("FAIL cooldown_end inv=%b want=0", invulnerable);
    end
  endtask

  task automatic test_gamestart_hit;
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    checks++;
    if (hitPoints !== 4'd2 || invulnerable !== 1'b0 || waiting !== 1'b0) begin
      fails++;
      $display("FAIL gs_hit_setup hp=%0d inv=%b waiting=%b want hp=2 inv=0 waiting=0", hitPoints, invulnerable, waiting);
    end
    step(0, 1, 1);
    checks++;
    if ({hitPoints, invulnerable, toggleY, waiting, defeatedPulse} !== 8'b0101_0010) begin
      fails++;
      $display("FAIL gs_beats_hit got=%b want=%b", {hitPoints, invulnerable, toggleY, waiting, defeatedPulse}, 8'b0101_0010);
    end
    step(0, 0, 0);
  endtask

  task automatic test_defeat;
    // Row: {sof, gameStart, hitIn, hp[3:0], inv, toggleY, waiting, defeatedPulse}
    logic [10:0] tbl [23];
    tbl = '{
      11'b010_0101_0010, 11'b100_0101_0010, 11'b100_0101_0010, 11'b100_0101_0000,
      11'b001_0100_1000, 11'b100_0100_1000, 11'b100_0100_0100, 11'b100_0100_0000,
      11'b101_0011_1100, 11'b100_0011_1000, 11'b100_0011_0100, 11'b001_0010_1100,
      11'b100_0010_1000, 11'b100_0010_0100, 11'b001_0001_1100, 11'b100_0001_1000,
      11'b100_0001_0100, 11'b100_0001_0000, 11'b101_0000_0011, 11'b000_0000_0010,
      11'b001_0000_0010, 11'b100_0000_0010, 11'b100_0000_0010
    };
    for (int r = 0; r < 23; r++) begin
      step(tbl[r][10], tbl[r][9], tbl[r][8]);
      checks++;
      if ({hitPoints, invulnerable, toggleY, waiting, defeatedPulse} !== tbl[r][7:0]) begin
        fails++;
        $display("FAIL defeat row=%0d got=%b want=%b", r, {hitPoints, invulnerable, toggleY, waiting, defeatedPulse}, tbl[r][7:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(0, 1, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    checks++;
    if ({hitPoints, invulnerable, toggleY, waiting, defeatedPulse} !== 8'b0100_1100) begin
      fails++;
      $display("FAIL reset_mid_setup got=%b want=%b", {hitPoints, invulnerable, toggleY, waiting, defeatedPulse}, 8'b0100_1100);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({hitPoints, invulnerable, toggleY, waiting, defeatedPulse} !== 8'b0101_0010) begin
      fails++;
      $display("FAIL async_reset got=%b want=%b", {hitPoints, invulnerable, toggleY, waiting, defeatedPulse}, 8'b0101_0010);
    end
    @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    checks++;
    if (waiting !== 1'b1 || toggleY !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle waiting=%b toggleY=%b want waiting=1 toggleY=0", waiting, toggleY);
    end
  endtask

  initial begin
    test_reset;
    test_arrive;
    test_dive;
    test_hit_hold;
    test_gamestart_hit;
    test_defeat;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
